lfs_seq_ctrl: RTL and testbench

Upstream sequencer for the 8-bit loadable shift register (LFS) stage.
- Accepts a seed and a shift count from a start pulse.
- Drives the LFS parallel-load data, load strobe and shift enable.
- After the requested number of shift cycles, captures the LFS output and reports it with a one-cycle done pulse.
- Sits between the stimulus/control logic and the LFS instance. Replaces hand-driven R/L/E sequencing.

---
 rtl/lfs_seq_ctrl_if.sv | 28 ++
 rtl/lfs_seq_ctrl.sv | 69 ++++++
 tb/tb_lfs_seq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lfs_seq_ctrl_if.sv
// Signal bundle between the LFS sequencer and its controller/LFS neighbours.
// start is a one-cycle request taken only while busy=0; done is a one-cycle pulse marking result valid.
interface lfs_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] R;
  logic             L;
  logic             E;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             done;
  logic [1:0]       dbg_state;

  modport slave (
    input  start, seed, count, q_in,
    output R, L, E, busy, result, done, dbg_state
  );

  modport master (
    output start, seed, count, q_in,
    input  R, L, E, busy, result, done, dbg_state
  );
endinterface

// File: rtl/lfs_seq_ctrl.sv
// Sequencer for the loadable shift register: load seed, shift count times, capture result.
// The FSM state is exported on dbg_state for checker binding.
module lfs_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic          clock,
  input  logic          resetn,
  lfs_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_SHIFT   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_LOAD;
      S_LOAD:    w_next = (r_cnt == '0) ? S_CAPTURE : S_SHIFT;
      // Leave on the last shift cycle so E is high exactly count cycles.
      S_SHIFT:   if (r_cnt == CNT_W'(1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_seed   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CAPTURE);
      if (w_accept) begin
        r_seed <= bus.seed;
        r_cnt  <= bus.count;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == S_CAPTURE) r_result <= bus.q_in;
    end
  end

  assign bus.R         = r_seed;
  assign bus.L         = (r_state == S_LOAD);
  assign bus.E         = (r_state == S_SHIFT);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lfs_seq_ctrl.sv
// Bench for lfs_seq_ctrl: an LFS model on R/L/E/q_in and a transaction-level reference
// (result = seed << count, E cycles = count, done count+2 edges after acceptance).
module tb_lfs_seq_ctrl;

  logic       clock;
  logic       resetn;
  logic [7:0] lfs_q;
  int         n_vec;
  int         n_err;

  lfs_seq_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

  lfs_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // LFS stage: parallel load has priority, otherwise left shift with zero fill
  always_ff @(posedge clock) begin
    if (!resetn)    lfs_q <= 8'h00;
    else if (bus.L) lfs_q <= bus.R;
    else if (bus.E) lfs_q <= {lfs_q[6:0], 1'b0};
  end
  assign bus.q_in = lfs_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one start and observe until done (or budget); returns in the done cycle.
  task automatic run_seq(input logic [7:0] s, input logic [7:0] c, input bit poke, input string tag);
    int         l_cyc;
    int         e_cyc;
    int         e_rise;
    int         both;
    int         done_at;
    logic       e_prev;
    logic [7:0] r_at_l;
    logic [7:0] exp_res;
    l_cyc   = 0;
    e_cyc   = 0;
    e_rise  = 0;
    both    = 0;
    done_at = -1;
    e_prev  = 1'b0;
    r_at_l  = 8'h00;
    exp_res = 8'((32'(s) << c) & 32'hFF);
    bus.start = 1'b1;
    bus.seed  = s;
    bus.count = c;
    step();
    bus.start = 1'b0;
    bus.seed  = 8'($urandom);
    bus.count = 8'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_prev_low"}, 32'(bus.done), 32'd0);
    for (int i = 0; i < int'(c) + 8; i++) begin
      if (bus.L) begin
        l_cyc++;
        r_at_l = bus.R;
      end
      if (bus.E) e_cyc++;
      if (bus.E && !e_prev) e_rise++;
      if (bus.E && bus.L) both++;
      e_prev = bus.E;
      if (bus.done) begin
        done_at = i;
        break;
      end
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.seed  = 8'h11;
        bus.count = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    check({tag, "_l_cycles"}, 32'(l_cyc), 32'd1);
    check({tag, "_r_at_load"}, 32'(r_at_l), 32'(s));
    check({tag, "_e_cycles"}, 32'(e_cyc), 32'(c));
    check({tag, "_e_bursts"}, 32'(e_rise), (c == 8'd0) ? 32'd0 : 32'd1);
    check({tag, "_l_e_overlap"}, 32'(both), 32'd0);
    check({tag, "_done_latency"}, 32'(done_at), 32'(c) + 32'd2);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.seed  = 8'h00;
    bus.count = 8'h00;

    // reset, then idle
    step();
    step();
    resetn = 1'b1;
    check("rst_R", 32'(bus.R), 32'd0);
    check("rst_L", 32'(bus.L), 32'd0);
    check("rst_E", 32'(bus.E), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    step();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // basic sequence: 0x95 shifted left 3 gives 0xA8
    run_seq(8'h95, 8'd3, 1'b0, "basic");
    check("basic_result_lit", 32'(bus.result), 32'hA8);
    step();
    check("basic_done_one_cycle", 32'(bus.done), 32'd0);
    check("basic_result_hold", 32'(bus.result), 32'hA8);

    // zero count
    run_seq(8'hC3, 8'd0, 1'b0, "zero");
    step();

    // start while busy is ignored, not queued
    run_seq(8'h3C, 8'd5, 1'b1, "ignored");
    for (int i = 0; i < 3; i++) begin
      step();
      check("ignored_no_second_load", 32'(bus.L), 32'd0);
      check("ignored_idle", 32'(bus.busy), 32'd0);
    end

    // back-to-back: second start issued in the done cycle
    run_seq(8'($urandom), 8'($urandom_range(1, 6)), 1'b0, "b2b_first");
    run_seq(8'h01, 8'd1, 1'b0, "b2b_second");
    step();

    // maximum count must not wrap
    run_seq(8'($urandom), 8'd255, 1'b0, "max_count");
    step();

    // randomized runs, some back-to-back
    for (int n = 0; n < 8; n++) begin
      run_seq(8'($urandom), 8'($urandom_range(0, 12)), 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // mid-sequence reset during SHIFT; reset then clears result back to 0
    bus.start = 1'b1;
    bus.seed  = 8'($urandom);
    bus.count = 8'd10;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("midrst_in_shift", 32'(bus.E), 32'd1);
    resetn = 1'b0;
    step();
    check("midrst_E", 32'(bus.E), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("midrst_no_late_done", 32'(bus.done), 32'd0);
    end

    // recovery after reset
    run_seq(8'($urandom), 8'($urandom_range(0, 9)), 1'b0, "recover");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
